// File: rtl/mem_port_arbiter.sv
// Arbitrates N_CH valid/good requestor channels onto one downstream memory port.
// One transaction is outstanding at a time; the grant is round-robin or fixed priority.
module mem_port_arbiter #(
    parameter int unsigned N_CH = 2,
    parameter int unsigned AW   = 32,
    parameter int unsigned DW   = 32,
    parameter int unsigned RR   = 1,
    localparam int unsigned IdW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_CH-1:0]      s_valid,
    input  logic [N_CH*AW-1:0]   s_addr,
    input  logic [N_CH*DW-1:0]   s_writeData,
    input  logic [N_CH-1:0]      s_memRead,
    input  logic [N_CH-1:0]      s_memWrite,
    input  logic [N_CH*2-1:0]    s_maskMode,
    input  logic [N_CH-1:0]      s_sext,
    output logic [N_CH-1:0]      s_good,
    output logic [DW-1:0]        s_readData,
    output logic                 m_valid,
    output logic [AW-1:0]        m_addr,
    output logic [DW-1:0]        m_writeData,
    output logic                 m_memRead,
    output logic                 m_memWrite,
    output logic [1:0]           m_maskMode,
    output logic                 m_sext,
    input  logic                 m_good,
    input  logic [DW-1:0]        m_readData,
    output logic [IdW-1:0]       grant_id
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StResp
    } state_e;

    state_e         state_q, state_d;
    logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0] grant_q, grant_d;

    logic           m_valid_q, m_valid_d;
    logic [AW-1:0]  m_addr_q, m_addr_d;
    logic [DW-1:0]  m_wdata_q, m_wdata_d;
    logic           m_rd_q, m_rd_d;
    logic           m_wr_q, m_wr_d;
    logic [1:0]     m_mask_q, m_mask_d;
    logic           m_sext_q, m_sext_d;

    logic [N_CH-1:0] s_good_q, s_good_d;
    logic [DW-1:0]   s_rdata_q, s_rdata_d;

    logic [IdW-1:0] winner;
    logic           any_valid;

    logic [AW-1:0]  sel_addr;
    logic [DW-1:0]  sel_wdata;
    logic           sel_rd;
    logic           sel_wr;
    logic [1:0]     sel_mask;
    logic           sel_sext;

    // Winner selection
    always_comb begin
        int unsigned idx;
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        if (RR != 0) begin
            // Search upward from the channel after the last one served, wrapping at N_CH.
            for (int unsigned k = 1; k <= N_CH; k++) begin
                idx = 32'(rr_ptr_q) + k;
                if (idx >= N_CH) begin
                    idx = idx - N_CH;
                end
                if (!any_valid && s_valid[IdW'(idx)]) begin
                    any_valid = 1'b1;
                    winner    = IdW'(idx);
                end
            end
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (!any_valid && s_valid[IdW'(i)]) begin
                    any_valid = 1'b1;
                    winner    = IdW'(i);
                end
            end
        end
    end

    // Request field mux for the winning channel
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_rd    = 1'b0;
        sel_wr    = 1'b0;
        sel_mask  = '0;
        sel_sext  = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (winner == IdW'(i)) begin
                sel_addr  = s_addr[i*AW +: AW];
                sel_wdata = s_writeData[i*DW +: DW];
                sel_rd    = s_memRead[i];
                sel_wr    = s_memWrite[i];
                sel_mask  = s_maskMode[i*2 +: 2];
                sel_sext  = s_sext[i];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        m_valid_d = m_valid_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_rd_d    = m_rd_q;
        m_wr_d    = m_wr_q;
        m_mask_d  = m_mask_q;
        m_sext_d  = m_sext_q;
        s_good_d  = '0;
        s_rdata_d = s_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    m_valid_d = 1'b1;
                    m_addr_d  = sel_addr;
                    m_wdata_d = sel_wdata;
                    m_rd_d    = sel_rd;
                    m_wr_d    = sel_wr;
                    m_mask_d  = sel_mask;
                    m_sext_d  = sel_sext;
                    grant_d   = winner;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                if (m_good) begin
                    m_valid_d = 1'b0;
                    s_rdata_d = m_readData;
                    for (int unsigned i = 0; i < N_CH; i++) begin
                        s_good_d[i] = (grant_q == IdW'(i));
                    end
                    rr_ptr_d = grant_q;
                    state_d  = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            rr_ptr_q  <= IdW'(N_CH - 1);
            grant_q   <= '0;
            m_valid_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_rd_q    <= 1'b0;
            m_wr_q    <= 1'b0;
            m_mask_q  <= '0;
            m_sext_q  <= 1'b0;
            s_good_q  <= '0;
            s_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            m_valid_q <= m_valid_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_rd_q    <= m_rd_d;
            m_wr_q    <= m_wr_d;
            m_mask_q  <= m_mask_d;
            m_sext_q  <= m_sext_d;
            s_good_q  <= s_good_d;
            s_rdata_q <= s_rdata_d;
        end
    end

    assign s_good      = s_good_q;
    assign s_readData  = s_rdata_q;
    assign m_valid     = m_valid_q;
    assign m_addr      = m_addr_q;
    assign m_writeData = m_wdata_q;
    assign m_memRead   = m_rd_q;
    assign m_memWrite  = m_wr_q;
    assign m_maskMode  = m_mask_q;
    assign m_sext      = m_sext_q;
    assign grant_id    = grant_q;

    a_good_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(s_good_q));

    a_req_stable: assert property (@(posedge clk) disable iff (!reset)
        (state_q == StIssue && !m_good) |=>
            (m_valid_q && $stable(m_addr_q) && $stable(m_wdata_q) && $stable(m_rd_q)
             && $stable(m_wr_q) && $stable(m_mask_q) && $stable(m_sext_q)));

    a_good_only_after_issue: assert property (@(posedge clk) disable iff (!reset)
        (s_good_q != '0) |-> (state_q == StResp && !m_valid_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random and directed stimulus for two arbiters (round-robin and fixed priority, 4 channels),
// checked by a transaction-level model feeding scoreboard queues drained by a monitor.
module tb_mem_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int ND = 2;
    localparam int IW = 2;
    localparam int FW = IW + AW + DW + 1 + 1 + 2 + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [N-1:0]    s_valid     [ND];
    logic [N*AW-1:0] s_addr      [ND];
    logic [N*DW-1:0] s_writeData [ND];
    logic [N-1:0]    s_memRead   [ND];
    logic [N-1:0]    s_memWrite  [ND];
    logic [N*2-1:0]  s_maskMode  [ND];
    logic [N-1:0]    s_sext      [ND];
    logic [N-1:0]    s_good      [ND];
    logic [DW-1:0]   s_readData  [ND];
    logic            m_valid     [ND];
    logic [AW-1:0]   m_addr      [ND];
    logic [DW-1:0]   m_writeData [ND];
    logic            m_memRead   [ND];
    logic            m_memWrite  [ND];
    logic [1:0]      m_maskMode  [ND];
    logic            m_sext      [ND];
    logic            m_good      [ND];
    logic [DW-1:0]   m_readData  [ND];
    logic [IW-1:0]   grant_id    [ND];

    mem_port_arbiter #(.N_CH(N), .AW(AW), .DW(DW), .RR(1)) u_rr (
        .clk(clk), .reset(reset),
        .s_valid(s_valid[0]), .s_addr(s_addr[0]), .s_writeData(s_writeData[0]),
        .s_memRead(s_memRead[0]), .s_memWrite(s_memWrite[0]), .s_maskMode(s_maskMode[0]),
        .s_sext(s_sext[0]), .s_good(s_good[0]), .s_readData(s_readData[0]),
        .m_valid(m_valid[0]), .m_addr(m_addr[0]), .m_writeData(m_writeData[0]),
        .m_memRead(m_memRead[0]), .m_memWrite(m_memWrite[0]), .m_maskMode(m_maskMode[0]),
        .m_sext(m_sext[0]), .m_good(m_good[0]), .m_readData(m_readData[0]),
        .grant_id(grant_id[0])
    );

    mem_port_arbiter #(.N_CH(N), .AW(AW), .DW(DW), .RR(0)) u_fp (
        .clk(clk), .reset(reset),
        .s_valid(s_valid[1]), .s_addr(s_addr[1]), .s_writeData(s_writeData[1]),
        .s_memRead(s_memRead[1]), .s_memWrite(s_memWrite[1]), .s_maskMode(s_maskMode[1]),
        .s_sext(s_sext[1]), .s_good(s_good[1]), .s_readData(s_readData[1]),
        .m_valid(m_valid[1]), .m_addr(m_addr[1]), .m_writeData(m_writeData[1]),
        .m_memRead(m_memRead[1]), .m_memWrite(m_memWrite[1]), .m_maskMode(m_maskMode[1]),
        .m_sext(m_sext[1]), .m_good(m_good[1]), .m_readData(m_readData[1]),
        .grant_id(grant_id[1])
    );

    typedef struct {
        int          due;
        logic [FW-1:0] v;
    } gexp_t;

    typedef struct {
        int          due;
        int          ch;
        logic [DW-1:0] data;
    } cexp_t;

    gexp_t gq [ND][$];
    cexp_t cq [ND][$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic rst_seen = 1'b0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
    end

    // Requestor state, memory model state, and the transaction-level reference
    bit            req_act   [ND][N];
    logic [AW-1:0] req_addr  [ND][N];
    logic [DW-1:0] req_wdata [ND][N];
    logic          req_rd    [ND][N];
    logic          req_wr    [ND][N];
    logic [1:0]    req_mask  [ND][N];
    logic          req_sext  [ND][N];

    int   phase   [ND];   // 0 free, 1 waiting for memory, 2 completion turnaround
    int   cur     [ND];
    int   last    [ND];
    int   mem_cnt [ND];

    logic          rst_req;
    bit            rand_en;
    int            req_pct;
    int            lat_force;
    bit            force_en;
    logic [DW-1:0] force_data;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic int pick(int d);
        if (d == 0) begin
            for (int k = 1; k <= N; k++) begin
                if (req_act[d][(last[d] + k) % N]) return (last[d] + k) % N;
            end
        end else begin
            for (int c = 0; c < N; c++) begin
                if (req_act[d][c]) return c;
            end
        end
        return -1;
    endfunction

    task automatic set_req(int d, int c, logic [AW-1:0] a, logic [DW-1:0] w, logic rd,
                           logic wr, logic [1:0] mk, logic sx);
        req_act[d][c]   = 1'b1;
        req_addr[d][c]  = a;
        req_wdata[d][c] = w;
        req_rd[d][c]    = rd;
        req_wr[d][c]    = wr;
        req_mask[d][c]  = mk;
        req_sext[d][c]  = sx;
    endtask

    task automatic drive(int d);
        for (int c = 0; c < N; c++) begin
            s_valid[d][c]             = req_act[d][c];
            s_addr[d][c*AW +: AW]     = req_addr[d][c];
            s_writeData[d][c*DW +: DW] = req_wdata[d][c];
            s_memRead[d][c]           = req_rd[d][c];
            s_memWrite[d][c]          = req_wr[d][c];
            s_maskMode[d][c*2 +: 2]   = req_mask[d][c];
            s_sext[d][c]              = req_sext[d][c];
        end
    endtask

    task automatic model_step(int d);
        int w;
        if (!rst_req) begin
            phase[d]   = 0;
            last[d]    = N - 1;
            mem_cnt[d] = -1;
            gq[d].delete();
            cq[d].delete();
            return;
        end
        case (phase[d])
            0: begin
                w = pick(d);
                if (w >= 0) begin
                    gq[d].push_back('{due: cyc + 1,
                        v: {IW'(w), req_addr[d][w], req_wdata[d][w], req_rd[d][w],
                            req_wr[d][w], req_mask[d][w], req_sext[d][w]}});
                    cur[d]   = w;
                    phase[d] = 1;
                end
            end
            1: begin
                if (m_good[d]) begin
                    cq[d].push_back('{due: cyc + 1, ch: cur[d], data: m_readData[d]});
                    last[d]  = cur[d];
                    phase[d] = 2;
                end
            end
            default: phase[d] = 0;
        endcase
    endtask

    // One clock: react to DUT outputs, issue requests, play memory, drive, update model.
    task automatic step();
        @(posedge clk);
        #1;
        reset = rst_req;
        for (int d = 0; d < ND; d++) begin
            for (int c = 0; c < N; c++) begin
                if (s_good[d][c] && rst_seen) req_act[d][c] = 1'b0;
                if (rand_en && !req_act[d][c] && $urandom_range(0, 99) < req_pct) begin
                    set_req(d, c, $urandom, $urandom, 1'($urandom), 1'($urandom),
                            2'($urandom), 1'($urandom));
                end
            end
            m_good[d] = 1'b0;
            if (m_valid[d]) begin
                if (mem_cnt[d] < 0) mem_cnt[d] = (lat_force >= 0) ? lat_force : $urandom_range(0, 3);
                if (mem_cnt[d] == 0) begin
                    m_good[d]     = 1'b1;
                    m_readData[d] = force_en ? force_data : $urandom;
                    mem_cnt[d]    = -1;
                end else begin
                    mem_cnt[d]--;
                end
            end else if (rand_en && $urandom_range(0, 9) == 0) begin
                m_good[d]     = 1'b1;    // stray completion while nothing is outstanding
                m_readData[d] = $urandom;
            end
            drive(d);
            model_step(d);
        end
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 400; i++) begin
            idle = 1'b1;
            for (int d = 0; d < ND; d++) begin
                if (phase[d] != 0 || gq[d].size() != 0 || cq[d].size() != 0) idle = 1'b0;
                for (int c = 0; c < N; c++) if (req_act[d][c]) idle = 1'b0;
            end
            if (idle) break;
            step();
        end
        chk("drain_idle", idle, 1);
    endtask

    task automatic directed(int c, logic [AW-1:0] a, logic [DW-1:0] w, logic rd, logic wr,
                            logic [1:0] mk, logic sx, int lat, logic [DW-1:0] data);
        bit [1:0] got;
        lat_force  = lat;
        force_en   = 1'b1;
        force_data = data;
        for (int d = 0; d < ND; d++) set_req(d, c, a, w, rd, wr, mk, sx);
        got = 2'b00;
        for (int i = 0; i < 30 && got != 2'b11; i++) begin
            step();
            for (int d = 0; d < ND; d++) begin
                if (s_good[d] != '0 && !got[d]) begin
                    got[d] = 1'b1;
                    chk("dir_s_good", s_good[d], 4'b0001 << c);
                    chk("dir_s_readData", s_readData[d], data);
                end
            end
        end
        chk("dir_completed", got, 2'b11);
        force_en  = 1'b0;
        lat_force = -1;
        wait_idle();
    endtask

    // Monitor: pops expected grants/completions exactly at the cycle they are due.
    logic          mv_prev [ND];
    logic          exp_mv  [ND];
    logic [FW-1:0] hold    [ND];

    initial begin
        gexp_t         g;
        cexp_t         e;
        logic [FW-1:0] obs;
        bit            rise;
        for (int d = 0; d < ND; d++) begin
            mv_prev[d] = 1'b0;
            exp_mv[d]  = 1'b0;
            hold[d]    = '0;
        end
        wait (cyc >= 1);
        forever begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                if (!rst_seen) begin
                    chk("reset_outputs",
                        {m_valid[d], s_good[d], grant_id[d], s_readData[d], m_addr[d],
                         m_writeData[d], m_memRead[d], m_memWrite[d], m_maskMode[d], m_sext[d]},
                        '0);
                    mv_prev[d] = 1'b0;
                    exp_mv[d]  = 1'b0;
                    continue;
                end
                obs  = {grant_id[d], m_addr[d], m_writeData[d], m_memRead[d], m_memWrite[d],
                        m_maskMode[d], m_sext[d]};
                rise = m_valid[d] && !mv_prev[d];
                if (gq[d].size() != 0 && gq[d][0].due <= cyc) begin
                    g = gq[d].pop_front();
                    chk($sformatf("grant_dut%0d", d), {rise, obs}, {1'b1, g.v});
                    hold[d]   = g.v;
                    exp_mv[d] = 1'b1;
                end else if (m_valid[d]) begin
                    chk($sformatf("request_hold_dut%0d", d), {rise, obs}, {1'b0, hold[d]});
                end
                if (cq[d].size() != 0 && cq[d][0].due <= cyc) begin
                    e = cq[d].pop_front();
                    chk($sformatf("complete_dut%0d", d), {s_good[d], s_readData[d]},
                        {4'b0001 << e.ch, e.data});
                    exp_mv[d] = 1'b0;
                end else begin
                    chk($sformatf("no_s_good_dut%0d", d), s_good[d], '0);
                end
                chk($sformatf("m_valid_dut%0d", d), m_valid[d], exp_mv[d]);
                mv_prev[d] = m_valid[d];
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        rst_req    = 1'b0;
        rand_en    = 1'b0;
        req_pct    = 0;
        lat_force  = -1;
        force_en   = 1'b0;
        force_data = '0;
        for (int d = 0; d < ND; d++) begin
            phase[d]      = 0;
            cur[d]        = 0;
            last[d]       = N - 1;
            mem_cnt[d]    = -1;
            m_good[d]     = 1'b0;
            m_readData[d] = '0;
            for (int c = 0; c < N; c++) set_req(d, c, '0, '0, 1'b0, 1'b0, 2'b00, 1'b0);
            for (int c = 0; c < N; c++) req_act[d][c] = 1'b0;
            drive(d);
        end

        repeat (3) step();
        for (int d = 0; d < ND; d++) begin
            chk("reset_m_valid", m_valid[d], 1'b0);
            chk("reset_s_good", s_good[d], 4'b0000);
            chk("reset_grant_id", grant_id[d], 2'd0);
        end
        rst_req = 1'b1;
        step();

        // Single read on ch1, then a write on ch1, then a zero-wait read on ch0
        directed(1, 32'h0000_0100, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 2, 32'hDEAD_BEEF);
        directed(1, 32'h0000_0204, 32'h1234_5678, 1'b0, 1'b1, 2'd1, 1'b0, 1, 32'h0BAD_F00D);
        directed(0, 32'h0000_0010, 32'h0, 1'b1, 1'b0, 2'd0, 1'b1, 0, 32'hCAFE_F00D);

        // Reset while a transaction waits for memory
        lat_force = 20;
        for (int d = 0; d < ND; d++) set_req(d, 0, 32'h300, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            if (m_valid[0] && m_valid[1]) break;
        end
        chk("midop_granted", {m_valid[1], m_valid[0]}, 2'b11);
        step();
        rst_req = 1'b0;
        for (int d = 0; d < ND; d++) req_act[d][0] = 1'b0;
        step();
        step();
        for (int d = 0; d < ND; d++) begin
            chk("midop_m_valid_cleared", m_valid[d], 1'b0);
            chk("midop_s_good_cleared", s_good[d], 4'b0000);
        end
        rst_req   = 1'b1;
        lat_force = -1;
        for (int d = 0; d < ND; d++) set_req(d, 1, 32'h400, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
        step();
        step();
        for (int d = 0; d < ND; d++) begin
            chk("post_reset_grant_id", grant_id[d], 2'd1);
            chk("post_reset_m_valid", m_valid[d], 1'b1);
            set_req(d, 0, 32'h500, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
        end
        wait_idle();

        // Randomised traffic: saturated, then moderate, then light
        rand_en = 1'b1;
        req_pct = 100;
        repeat (400) step();
        req_pct = 40;
        repeat (1500) step();
        req_pct = 15;
        repeat (800) step();
        rand_en = 1'b0;
        wait_idle();
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
